// File: rtl/spi_dac_pkg.sv
// Shared constants and types for the SPI DAC responder.
// Frame layout (MSB first, 16 bits):
//   [15] must be 0, [14] BUF, [13] GA, [12] SHDN, [11:2] value, [1:0] ignored.
package spi_dac_pkg;

    localparam int FRAME_BITS = 16;
    localparam int BIT_BUF    = 14;
    localparam int BIT_GA     = 13;
    localparam int BIT_SHDN   = 12;
    localparam int VAL_MSB    = 11;
    localparam int VAL_LSB    = 2;
    localparam int VAL_W      = VAL_MSB - VAL_LSB + 1;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    typedef struct packed {
        logic [VAL_W-1:0] value;
        logic             buf_en;
        logic             gain1x;
        logic             active;
    } dac_reg_t;

    localparam dac_reg_t DAC_RST = '{value: '0, buf_en: 1'b0, gain1x: 1'b1, active: 1'b0};

    // Only the meaningful field bits are passed in.
    function automatic dac_reg_t decode_frame(input logic [BIT_BUF:VAL_LSB] f);
        dac_reg_t r;
        r.value  = f[VAL_MSB:VAL_LSB];
        r.buf_en = f[BIT_BUF];
        r.gain1x = f[BIT_GA];
        r.active = f[BIT_SHDN];
        return r;
    endfunction

endpackage

// File: rtl/spi_dac_responder_if.sv
// Pin bundle for the SPI DAC responder: SPI inputs plus latched DAC outputs
// and status pulses. master = SPI initiator / observer side, slave = responder.
interface spi_dac_responder_if;
    logic       cs;
    logic       sck;
    logic       sdi;
    logic       ld;
    logic [9:0] value;
    logic       gain1x;
    logic       buf_en;
    logic       active;
    logic       frame_valid;
    logic       frame_err;
    logic       load_strobe;

    modport master (
        output cs, sck, sdi, ld,
        input  value, gain1x, buf_en, active, frame_valid, frame_err, load_strobe
    );

    modport slave (
        input  cs, sck, sdi, ld,
        output value, gain1x, buf_en, active, frame_valid, frame_err, load_strobe
    );
endinterface

// File: rtl/spi_dac_responder_sync_edge.sv
// sync_edge: STAGES-deep synchroniser with rise/fall detection.
// Ports: clk/rst (async high), din (asynchronous pin), q (synchronised level),
//        rise/fall (one-cycle pulses, q versus its one-cycle-delayed copy).
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_dac_responder.sv
// spi_dac_responder: SPI slave for a 10-bit DAC command frame.
// Ports: sysclk, reset (async high); dac_cs/dac_sck/dac_sdi/dac_ld (async SPI
// pins, CS and LD active low); dac_value/dac_gain1x/dac_buf/dac_active
// (latched DAC outputs); frame_valid/frame_err/load_strobe (one-cycle pulses).
module spi_dac_responder
    import spi_dac_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             dac_cs,
    input  logic             dac_sck,
    input  logic             dac_sdi,
    input  logic             dac_ld,
    output logic [VAL_W-1:0] dac_value,
    output logic             dac_gain1x,
    output logic             dac_buf,
    output logic             dac_active,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             load_strobe
);
    localparam int FLUSH = SYNC_STAGES + 1;
    localparam int FW    = $clog2(FLUSH + 1);

    logic cs_q, cs_rise, cs_fall;
    logic sck_q, sck_rise, sck_fall;
    logic sdi_q, sdi_rise, sdi_fall;
    logic ld_q, ld_rise, ld_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(sysclk), .rst(reset), .din(dac_cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(sysclk), .rst(reset), .din(dac_sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
        .clk(sysclk), .rst(reset), .din(dac_sdi), .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ld (
        .clk(sysclk), .rst(reset), .din(dac_ld), .q(ld_q), .rise(ld_rise), .fall(ld_fall));

    // The synchronisers come out of reset at idle levels, so a pin already
    // low at release shows up as a false falling edge. Ignore edges until the
    // chains have flushed, and only arm frame start once CS is seen high.
    logic [FW-1:0] flush_cnt;
    logic          settled;
    logic          armed;

    assign settled = (flush_cnt == FW'(FLUSH));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (!settled)        flush_cnt <= flush_cnt + FW'(1);
            if (settled && cs_q) armed     <= 1'b1;
        end
    end

    state_t state, nxt;
    logic   start, shift_en, check, accept;

    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    dac_reg_t              in_reg, out_reg;
    logic                  load_req;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (cs_fall && armed) nxt = ST_SHIFT;
            ST_SHIFT: if (cs_rise)          nxt = ST_CHECK;
            ST_CHECK:                       nxt = ST_IDLE;
            default:                        nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start    = (state == ST_IDLE) && cs_fall && armed;
        shift_en = (state == ST_SHIFT) && sck_rise;
        check    = (state == ST_CHECK);
        accept   = check && (bit_cnt == CNT_W'(FRAME_BITS)) && !shreg[FRAME_BITS-1];
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            in_reg      <= DAC_RST;
            out_reg     <= DAC_RST;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            load_req    <= 1'b0;
            load_strobe <= 1'b0;
        end else begin
            if (start) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg <= {shreg[FRAME_BITS-2:0], sdi_q};
                if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
            end
            frame_valid <= accept;
            frame_err   <= check && !accept;
            if (accept) in_reg <= decode_frame(shreg[BIT_BUF:VAL_LSB]);
            // Transfer happens one cycle after the LD edge, so an LD edge in
            // the CHECK cycle picks up the frame accepted in that same cycle.
            load_req    <= ld_fall && cs_q && armed;
            load_strobe <= load_req;
            if (load_req) out_reg <= in_reg;
        end
    end

    assign dac_value  = out_reg.value;
    assign dac_gain1x = out_reg.gain1x;
    assign dac_buf    = out_reg.buf_en;
    assign dac_active = out_reg.active;

    logic unused_sig;
    assign unused_sig = ^{sck_q, sck_fall, sdi_rise, sdi_fall, ld_q, ld_rise,
                          shreg[VAL_LSB-1:0]};
endmodule

// File: tb/tb_spi_dac_responder.sv
// Randomised bench for spi_dac_responder with a frame-level reference model.
module tb_spi_dac_responder;
    import spi_dac_pkg::*;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #10 sysclk = ~sysclk;

    spi_dac_responder_if bus();

    spi_dac_responder #(.SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .reset(reset),
        .dac_cs(bus.cs), .dac_sck(bus.sck), .dac_sdi(bus.sdi), .dac_ld(bus.ld),
        .dac_value(bus.value), .dac_gain1x(bus.gain1x), .dac_buf(bus.buf_en),
        .dac_active(bus.active), .frame_valid(bus.frame_valid),
        .frame_err(bus.frame_err), .load_strobe(bus.load_strobe)
    );

    localparam dac_reg_t M_RST = '{value: 10'd0, buf_en: 1'b0, gain1x: 1'b1, active: 1'b0};

    int n_chk = 0, n_pass = 0;
    int fv_cnt = 0, fe_cnt = 0, ls_cnt = 0, both_cnt = 0;
    dac_reg_t in_m, out_m;

    always @(negedge sysclk) begin
        if (bus.frame_valid) fv_cnt++;
        if (bus.frame_err) fe_cnt++;
        if (bus.load_strobe) ls_cnt++;
        if (bus.frame_valid && bus.frame_err) both_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, got no finish, exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    function automatic dac_reg_t model_decode(input logic [31:0] d);
        dac_reg_t r;
        r.value  = 10'((d >> 2) & 32'h3FF);
        r.buf_en = d[14];
        r.gain1x = d[13];
        r.active = d[12];
        return r;
    endfunction

    task automatic chk_outs(input string tag);
        chk({tag, ".value"},  bus.value,  out_m.value);
        chk({tag, ".gain1x"}, bus.gain1x, out_m.gain1x);
        chk({tag, ".buf"},    bus.buf_en, out_m.buf_en);
        chk({tag, ".active"}, bus.active, out_m.active);
    endtask

    task automatic ld_pulse(input string tag);
        int ls0 = ls_cnt;
        bus.ld = 1'b0;
        cyc(4);
        bus.ld = 1'b1;
        cyc(8);
        out_m = in_m;
        chk({tag, ".ls"}, ls_cnt - ls0, 1);
        chk_outs(tag);
    endtask

    // n bits of d, MSB first. ld_mid >= 0: LD pulsed low during that bit (CS low).
    // ld_late: LD falls one sysclk after CS rises (lands on the check cycle).
    task automatic frame(input string tag, input logic [31:0] d, input int n,
                         input int ld_mid, input bit ld_late);
        int fv0 = fv_cnt, fe0 = fe_cnt, ls0 = ls_cnt;
        bit good;
        bus.cs = 1'b0;
        cyc(4);
        for (int i = n - 1; i >= 0; i--) begin
            bus.sdi = d[i];
            if (i == ld_mid) bus.ld = 1'b0;
            cyc(4);
            bus.sck = 1'b1;
            cyc(4);
            bus.sck = 1'b0;
            bus.ld  = 1'b1;
        end
        cyc(4);
        bus.cs = 1'b1;
        good = (n == 16) && !d[15];
        if (good) in_m = model_decode(d);
        if (ld_late) begin
            cyc(1);
            bus.ld = 1'b0;
            cyc(4);
            bus.ld = 1'b1;
            out_m = in_m;
        end
        cyc(10);
        chk({tag, ".fv"}, fv_cnt - fv0, 32'(good));
        chk({tag, ".fe"}, fe_cnt - fe0, 32'(!good));
        chk({tag, ".ls"}, ls_cnt - ls0, 32'(ld_late));
        chk_outs(tag);
    endtask

    initial begin
        logic [31:0] d;
        int n, ldm;
        bit late;
        int fv0, fe0;

        bus.cs = 1'b1; bus.sck = 1'b0; bus.sdi = 1'b0; bus.ld = 1'b1;
        in_m = M_RST; out_m = M_RST;
        cyc(3);
        chk("rst.fv", bus.frame_valid, 0);
        chk("rst.fe", bus.frame_err, 0);
        chk("rst.ls", bus.load_strobe, 0);
        chk_outs("rst");
        reset = 1'b0;
        cyc(6);

        frame("t035", 32'h3A94, 16, -1, 1'b0);
        ld_pulse("t035.ld");
        chk("t035.abs", bus.value, 10'h2A5);

        frame("t036", 32'hBA94, 16, -1, 1'b0);
        ld_pulse("t036.ld");
        chk("t036.abs", bus.value, 10'h2A5);

        frame("t037.15", 32'h1FFC, 15, -1, 1'b0);
        frame("t037.17", 32'h0_1FFC, 17, -1, 1'b0);
        ld_pulse("t037.ld");

        frame("t038", 32'h33FC, 16, 8, 1'b0);
        ld_pulse("t038.ld");

        // reset in the middle of a frame
        fe0 = fe_cnt; fv0 = fv_cnt;
        bus.cs = 1'b0;
        cyc(4);
        for (int i = 15; i >= 8; i--) begin
            bus.sdi = 1'b1; cyc(4); bus.sck = 1'b1; cyc(4); bus.sck = 1'b0;
        end
        reset = 1'b1; bus.cs = 1'b1;
        cyc(3);
        reset = 1'b0;
        in_m = M_RST; out_m = M_RST;
        cyc(8);
        chk("t039.rst_fe", fe_cnt - fe0, 0);
        chk("t039.rst_fv", fv_cnt - fv0, 0);
        chk_outs("t039.rst");
        frame("t039", 32'h1004, 16, -1, 1'b0);
        ld_pulse("t039.ld");
        chk("t039.abs_v", bus.value, 10'h001);
        chk("t039.abs_g", bus.gain1x, 0);
        chk("t039.abs_a", bus.active, 1);

        frame("t040.a", 32'h3004, 16, -1, 1'b0);
        frame("t040.b", 32'h3FFC, 16, -1, 1'b0);
        ld_pulse("t040.ld");
        chk("t040.abs", bus.value, 10'h3FF);

        // CS already low when reset releases: no frame may start
        reset = 1'b1; bus.cs = 1'b0;
        cyc(3);
        reset = 1'b0;
        in_m = M_RST; out_m = M_RST;
        fe0 = fe_cnt; fv0 = fv_cnt;
        for (int i = 15; i >= 0; i--) begin
            bus.sdi = (i == 12 || i == 2); cyc(4); bus.sck = 1'b1; cyc(4); bus.sck = 1'b0;
        end
        cyc(4);
        bus.cs = 1'b1;
        cyc(10);
        chk("t032.fe", fe_cnt - fe0, 0);
        chk("t032.fv", fv_cnt - fv0, 0);
        frame("t032.next", 32'h2828, 16, -1, 1'b0);

        frame("t025", 32'h5154, 16, -1, 1'b1);

        for (int k = 0; k < 20; k++) begin
            d = $urandom;
            case ($urandom_range(0, 4))
                0: n = 15;
                1: n = 17;
                default: n = 16;
            endcase
            if ($urandom_range(0, 1) == 0) d[15] = 1'b0;
            ldm  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            late = ($urandom_range(0, 3) == 0);
            frame($sformatf("rnd%0d", k), d, n, ldm, late);
            if ($urandom_range(0, 1) == 0) ld_pulse($sformatf("rnd%0d.ld", k));
        end

        chk("both_pulses", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
